// File: rtl/output_stream.sv
// output_stream: sink stage below a bottom-row node's DOWN port.
// Each value the node writes is captured in order into an internal buffer.
// The host reads the buffer back and watches done/full.
// Optional checker compiles in under `OUTPUT_STREAM_CHECK_EN`. It adds an
// expected-list RAM, the exp_* write port and the mismatches/first_bad/pass outputs.
module output_stream #(
  parameter int unsigned DEPTH = 39,
  parameter int unsigned AW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [AW-1:0]        length,
  input  logic                 wvalid,
  input  logic signed [10:0]   in,
  output logic                 wready,
  output logic [AW-1:0]        count,
  output logic                 done,
  output logic                 full,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [10:0]   rd_data
`ifdef OUTPUT_STREAM_CHECK_EN
  ,
  input  logic                 exp_we,
  input  logic [AW-1:0]        exp_addr,
  input  logic signed [10:0]   exp_data,
  output logic [AW-1:0]        mismatches,
  output logic [AW-1:0]        first_bad,
  output logic                 pass
`endif
);

  typedef enum logic [1:0] {IDLE, ACK, STALL} stateT;

  stateT              state;
  logic [AW-1:0]      effLen;
  logic               capture;
  logic signed [10:0] mem [DEPTH];

  // Requested length clamped to buffer capacity; done/full follow count and length directly
  always_comb begin
    effLen  = (length > AW'(DEPTH)) ? AW'(DEPTH) : length;
    full    = (count == AW'(DEPTH));
    done    = (length != '0) && (count >= effLen);
    capture = (state == IDLE) && wvalid && !full && !done && !clear;
  end

  // Handshake FSM: capture in IDLE, pulse wready in ACK, hold off in STALL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      wready <= 1'b0;
    end else if (clear) begin
      state  <= IDLE;
      count  <= '0;
      wready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wready <= 1'b0;
          if (capture) begin
            count  <= count + AW'(1);
            wready <= 1'b1;
            state  <= ACK;
          end
        end
        ACK: begin
          wready <= 1'b0;
          state  <= (full || done) ? STALL : IDLE;
        end
        STALL: begin
          wready <= 1'b0;
          if (!full && !done) state <= IDLE;
        end
        default: begin
          wready <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Capture buffer; contents survive reset and are masked on readback by count
  always_ff @(posedge clk) begin
    if (capture) mem[count] <= in;
  end

  // Host readback, zero beyond the captured region
  always_comb begin
    rd_data = '0;
    if (rd_addr < count) rd_data = mem[rd_addr];
  end

`ifdef OUTPUT_STREAM_CHECK_EN
  logic signed [10:0] expMem [DEPTH];
  logic               isBad;
  logic [AW-1:0]      countNext;
  logic [AW-1:0]      misNext;
  logic               doneNext;

  // Expected-list RAM; a same-cycle write to the compared entry is seen next capture
  always_ff @(posedge clk) begin
    if (exp_we && (exp_addr < AW'(DEPTH))) expMem[exp_addr] <= exp_data;
  end

  // Post-edge view of count, mismatches and done used to register pass
  always_comb begin
    isBad     = capture && (in != expMem[count]);
    countNext = capture ? count + AW'(1) : count;
    misNext   = isBad ? mismatches + AW'(1) : mismatches;
    doneNext  = (length != '0) && (countNext >= effLen);
  end

  // Checker scoreboard: mismatch count, first bad index, pass flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatches <= '0;
      first_bad  <= AW'(DEPTH);
      pass       <= 1'b0;
    end else if (clear) begin
      mismatches <= '0;
      first_bad  <= AW'(DEPTH);
      pass       <= 1'b0;
    end else begin
      mismatches <= misNext;
      if (isBad && (first_bad == AW'(DEPTH))) first_bad <= count;
      pass <= doneNext && (misNext == '0);
    end
  end
`endif

endmodule

// File: doc/output_stream.md
# output_stream

Sink stage that sits directly downstream of a bottom-row node's DOWN port. It consumes the values that node writes, using the node's port handshake, and stores them in order in an internal buffer. The host reads the buffer back and sees a done flag once the expected number of values has arrived. An optional checker compares each captured value against a host-loaded expected list.

## Interface
Parameters:
- DEPTH, 39: buffer capacity in values.
- AW, $clog2(DEPTH+1): width of counts and addresses.

Ports:
- clk  in  1  clock; sole clock domain.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous restart; same effect as rst, applied on the clk edge.
- length  in  AW  number of values expected. Sampled continuously. Values above DEPTH are treated as DEPTH.
- wvalid  in  1  node's write bit for its DOWN direction.
- in  in  11  signed value from node `out`.
- wready  out  1  acknowledge to node's wready DOWN bit; one-cycle pulse.
- count  out  AW  number of values captured.
- done  out  1  high when count ≥ min(length, DEPTH) and length≠0.
- full  out  1  high when count == DEPTH.
- rd_addr  in  AW  host readback address.
- rd_data  out  11  buffer[rd_addr], combinational. Returns 0 when rd_addr ≥ count.
- exp_we, exp_addr[AW], exp_data[11]  in  expected-list write port. Present only with the checker compiled in.
- mismatches  out  AW  mismatch count. Present only with the checker compiled in.
- first_bad  out  AW  index of the first mismatch. Present only with the checker compiled in.
- pass  out  1  pass flag. Present only with the checker compiled in.

## Operation
- FSM states:
  - IDLE: accepting.
  - ACK: acknowledge cycle.
  - STALL: buffer full, or done reached.
- IDLE:
  - If wvalid=1 and count<DEPTH and !done: write `in` to buffer[count], increment count, go to ACK.
  - Otherwise stay in IDLE.
- ACK:
  - wready=1 for exactly this cycle.
  - wvalid is ignored.
  - Next state is STALL if full or done, else IDLE.
- STALL:
  - wready held 0, so the node blocks on its write.
  - Leave STALL for IDLE only when clear is asserted, or when length is raised so that done drops and full=0.
- Values are stored as 11-bit two's complement without modification. No saturation happens here; range −999..999 is the node's responsibility.
- rst or clear:
  - count=0, state=IDLE, wready=0, done=0, full=0.
  - Buffer contents are not cleared; rd_data masks them by count.
  - Checker state also resets: mismatches=0, first_bad=DEPTH, pass=0.
  - The expected list is not cleared.
- clear takes priority over a simultaneous capture: the value is dropped and count=0.

## Timing
- Capture at edge t, when IDLE and wvalid.
- At t+1: count updated and wready=1.
- At t+2: wready=0.
- Maximum throughput is one value per 2 cycles. A wvalid held continuously yields a capture every 2 cycles.
- done and full are registered-state derived: they are valid in the same cycle count updates (t+1).
- Reset mid-handshake: if rst asserts during ACK, wready drops asynchronously and the value already captured is lost along with count.
- length change: takes effect on done combinationally the same cycle.

## Configuration
- OUTPUT_STREAM_CHECK_EN: compiles in the expected-list RAM (DEPTH×11), the exp_* ports and mismatches/first_bad/pass.
- With the macro defined:
  - On each capture, compare `in` with expected[count].
  - On inequality, mismatches increments, and first_bad=count if first_bad==DEPTH.
  - pass = done && mismatches==0, registered, valid from t+1 of the final capture.
  - exp_we writes to the expected list are allowed at any time. A write to the address being compared in the same cycle uses the old value.
- Without the macro: those ports and the logic are absent, and capture behaviour is identical.

## Test plan
- Reset then idle: after rst, wready=0, count=0, done=0, full=0, rd_data(0)=0. With wvalid=0 for 10 cycles, nothing changes.
- Three writes with length=3 (values 5, −7, 999, wvalid held until each ack): wready pulses 3 times, 2 cycles apart. count=3, done=1, buffer reads back 5, −7, 999.
- Overflow with length=0, DEPTH=39: 40 writes → 39 acks, full=1. The 40th value is never acked and wready stays 0 while wvalid stays high.
- Mid-stream clear: after 2 captures, assert clear in the same cycle as wvalid → count=0 and no wready pulse. The next write is stored at index 0.
- Async reset during ACK: rst asserted mid-cycle → wready falls immediately and count=0 before the next edge.
- Checker (macro on): expected = 1, 2, 3, actual = 1, 9, 3, length=3 → mismatches=1, first_bad=1, pass=0. Then clear, rerun with 1, 2, 3 → pass=1.
